// File: rtl/stream_argmax_comparator.sv
// Streaming argmax: tracks the largest beat of a vector, its position and the beat count.
// Ports: Clock/ResetN (sync, active-low), InValid/InReady/DataIn/InLast in, OutValid/OutReady/MaxData/MaxIndex/Count/Overflow out.
// Optional macro ARGMAX_TIE_LAST_EN: equal beats replace the max, so the last occurrence wins.
module stream_argmax_comparator #(
  parameter int WIDTH          = 8,
  parameter bit TwosComplement = 1'b1,
  parameter int INDEX_WIDTH    = 4
) (
  input  logic                   Clock,
  input  logic                   ResetN,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [WIDTH-1:0]       DataIn,
  input  logic                   InLast,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [WIDTH-1:0]       MaxData,
  output logic [INDEX_WIDTH-1:0] MaxIndex,
  output logic [INDEX_WIDTH-1:0] Count,
  output logic                   Overflow
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic [INDEX_WIDTH-1:0] SAT = '1;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       max_q, max_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0] pos_q, pos_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;

  logic accept;
  logic gt;
  logic eq;
  logic take;

  assign accept = InValid && (state_q != HOLD);
  assign eq     = (DataIn == max_q);

  if (TwosComplement) begin : g_signed
    assign gt = $signed(DataIn) > $signed(max_q);
  end else begin : g_unsigned
    assign gt = DataIn > max_q;
  end

`ifdef ARGMAX_TIE_LAST_EN
  assign take = gt || eq;
`else
  assign take = gt;
`endif

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY, ACCUM: begin
        if (accept) state_d = InLast ? HOLD : ACCUM;
      end
      HOLD: begin
        if (OutReady) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    InReady  = (state_q != HOLD);
    OutValid = (state_q == HOLD);
  end

  // full_q marks that the saturated position is already occupied,
  // so only a beat beyond 2^INDEX_WIDTH flags Overflow.
  always_comb begin
    max_d  = max_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (accept) begin
      if (state_q == EMPTY) begin
        max_d = DataIn;
        idx_d = '0;
      end else if (take) begin
        max_d = DataIn;
        idx_d = pos_q;
      end
      pos_d  = (pos_q == SAT) ? SAT : pos_q + 1'b1;
      cnt_d  = (cnt_q == SAT) ? SAT : cnt_q + 1'b1;
      full_d = full_q | (pos_q == SAT);
      ovf_d  = ovf_q | full_q;
    end else if ((state_q == HOLD) && OutReady) begin
      cnt_d  = '0;
      pos_d  = '0;
      full_d = 1'b0;
      ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      max_q  <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      pos_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      max_q  <= max_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign MaxData  = max_q;
  assign MaxIndex = idx_q;
  assign Count    = cnt_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_stream_argmax_comparator.sv
// Scoreboard bench: three argmax instances (signed/4, unsigned/4, signed/2) share one stream.
// Expected results come from a queue-based reference model; a monitor checks each presented result.
module tb_stream_argmax_comparator;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

`ifdef ARGMAX_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  logic       Clock;
  logic       ResetN;
  logic       InValid;
  logic [7:0] DataIn;
  logic       InLast;
  logic       OutReady;

  logic       rdy0, rdy1, rdy2;
  logic       ov0, ov1, ov2;
  logic [7:0] md0, md1, md2;
  logic [3:0] mi0, mi1, cn0, cn1;
  logic [1:0] mi2, cn2;
  logic       of0, of1, of2;

  int  checks;
  int  failures;
  bit  manual;
  exp_t q0[$], q1[$], q2[$];

  stream_argmax_comparator #(.WIDTH(8), .TwosComplement(1'b1), .INDEX_WIDTH(4)) u_s4 (
    .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(rdy0),
    .DataIn(DataIn), .InLast(InLast), .OutValid(ov0), .OutReady(OutReady),
    .MaxData(md0), .MaxIndex(mi0), .Count(cn0), .Overflow(of0));

  stream_argmax_comparator #(.WIDTH(8), .TwosComplement(1'b0), .INDEX_WIDTH(4)) u_u4 (
    .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(rdy1),
    .DataIn(DataIn), .InLast(InLast), .OutValid(ov1), .OutReady(OutReady),
    .MaxData(md1), .MaxIndex(mi1), .Count(cn1), .Overflow(of1));

  stream_argmax_comparator #(.WIDTH(8), .TwosComplement(1'b1), .INDEX_WIDTH(2)) u_s2 (
    .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(rdy2),
    .DataIn(DataIn), .InLast(InLast), .OutValid(ov2), .OutReady(OutReady),
    .MaxData(md2), .MaxIndex(mi2), .Count(cn2), .Overflow(of2));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic exp_t model(input byte_q_t v, input bit sgn, input int iw);
    exp_t       e;
    int         sat;
    int         n;
    int         bi;
    logic [7:0] best;
    bit         gt;
    bit         take;
    sat  = (1 << iw) - 1;
    n    = v.size();
    best = 8'd0;
    bi   = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        take = 1'b1;
      end else begin
        gt   = sgn ? ($signed(v[i]) > $signed(best)) : (v[i] > best);
        take = gt || (TIE_LAST && (v[i] == best));
      end
      if (take) begin
        best = v[i];
        bi   = (i < sat) ? i : sat;
      end
    end
    e.d   = best;
    e.idx = 4'(bi);
    e.cnt = 4'((n < sat) ? n : sat);
    e.ovf = (n > sat + 1);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_out(input string who, input logic v, input logic [7:0] d,
                         input logic [3:0] idx, input logic [3:0] cnt,
                         input logic ovf, input exp_t e);
    checks++;
    if (v !== 1'b1 || d !== e.d || idx !== e.idx || cnt !== e.cnt || ovf !== e.ovf) begin
      failures++;
      $display("FAIL result_%s: got v=%b d=%h idx=%0d cnt=%0d ovf=%b expected v=1 d=%h idx=%0d cnt=%0d ovf=%b",
               who, v, d, idx, cnt, ovf, e.d, e.idx, e.cnt, e.ovf);
    end
  endtask

  // Monitor: compares whatever the DUTs present against the queue head;
  // holding the head while OutReady=0 also checks output stability.
  always @(negedge Clock) begin
    if (ResetN && ov0) begin
      if (q0.size() == 0) begin
        chk("spurious_outvalid", 32'(ov0), 32'd0);
      end else begin
        cmp_out("s4", ov0, md0, mi0, cn0, of0, q0[0]);
        cmp_out("u4", ov1, md1, mi1, cn1, of1, q1[0]);
        cmp_out("s2", ov2, md2, {2'b00, mi2}, {2'b00, cn2}, of2, q2[0]);
        chk("inready_in_hold", 32'({rdy0, rdy1, rdy2}), 32'd0);
        if (OutReady) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
          void'(q2.pop_front());
        end
      end
    end
  end

  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      if (!manual) OutReady = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_beat(input logic [7:0] d, input bit last);
    int n;
    InValid = 1'b1;
    DataIn  = d;
    InLast  = last;
    n = 0;
    while (!rdy0 && n < 200) begin
      @(posedge Clock);
      #1;
      n++;
    end
    if (n >= 200) chk("inready_timeout", 32'd0, 32'd1);
    @(posedge Clock);
    #1;
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic send_vec(input byte_q_t v);
    for (int i = 0; i < v.size(); i++) begin
      send_beat(v[i], i == v.size() - 1);
      if (i == v.size() - 1) begin
        q0.push_back(model(v, 1'b1, 4));
        q1.push_back(model(v, 1'b0, 4));
        q2.push_back(model(v, 1'b1, 2));
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 500) begin
      @(posedge Clock);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'(q0.size()), 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_inready", 32'({rdy0, rdy1, rdy2}), 32'h7);
    chk("rst_outvalid", 32'({ov0, ov1, ov2}), 32'h0);
    chk("rst_maxdata", 32'({md0, md1, md2}), 32'h0);
    chk("rst_index_count", 32'({mi0, mi1, mi2, cn0, cn1, cn2}), 32'h0);
    chk("rst_overflow", 32'({of0, of1, of2}), 32'h0);
  endtask

  initial begin
    byte_q_t v;
    int      len;
    checks   = 0;
    failures = 0;
    manual   = 1'b1;
    ResetN   = 1'b0;
    InValid  = 1'b0;
    InLast   = 1'b0;
    DataIn   = 8'h00;
    repeat (3) @(posedge Clock);
    #1;
    ResetN = 1'b1;
    @(negedge Clock);
    chk_reset_vals();
    @(posedge Clock);
    #1;

    v = {8'd3, 8'hFB, 8'd7, 8'd2};
    send_vec(v);
    @(negedge Clock);
    chk("signed_order", 32'({ov0, md0, mi0, cn0, of0}), 32'({1'b1, 8'd7, 4'd2, 4'd4, 1'b0}));
    chk("unsigned_order", 32'({ov1, md1, mi1, cn1}), 32'({1'b1, 8'hFB, 4'd1, 4'd4}));
    drain();

    v = {8'd4, 8'd9, 8'd9};
    send_vec(v);
    @(negedge Clock);
    chk("tie_break_index", 32'(mi0), TIE_LAST ? 32'd2 : 32'd1);
    drain();

    OutReady = 1'b0;
    v = {8'h80};
    send_vec(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("bp_hold", 32'({ov0, rdy0, md0, mi0, cn0}), 32'({1'b1, 1'b0, 8'h80, 4'd0, 4'd1}));
      @(posedge Clock);
      #1;
    end
    OutReady = 1'b1;
    @(posedge Clock);
    #1;
    chk("bp_release", 32'({rdy0, ov0, cn0, of0}), 32'({1'b1, 1'b0, 4'd0, 1'b0}));

    v = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    send_vec(v);
    @(negedge Clock);
    chk("overflow_iw2", 32'({md2, mi2, cn2, of2}), 32'({8'd6, 2'd3, 2'd3, 1'b1}));
    chk("no_overflow_iw4", 32'({cn0, of0}), 32'({4'd6, 1'b0}));
    drain();

    send_beat(8'd50, 1'b0);
    send_beat(8'd60, 1'b0);
    InValid = 1'b1;
    DataIn  = 8'h77;
    InLast  = 1'b1;
    ResetN  = 1'b0;
    @(posedge Clock);
    #1;
    ResetN  = 1'b1;
    InValid = 1'b0;
    InLast  = 1'b0;
    @(negedge Clock);
    chk_reset_vals();
    repeat (4) @(posedge Clock);
    #1;
    v = {8'd10, 8'd20};
    send_vec(v);
    @(negedge Clock);
    chk("after_reset_vec", 32'({ov0, md0, mi0, cn0}), 32'({1'b1, 8'd20, 4'd1, 4'd2}));
    drain();

    manual = 1'b0;
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, 7);
      v = {};
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) v.push_back(8'($urandom_range(0, 3)));
        else v.push_back(8'($urandom));
      end
      send_vec(v);
    end
    drain();
    manual   = 1'b1;
    OutReady = 1'b1;
    repeat (3) @(posedge Clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
